// File: rtl/delayer_arb_rr_pkg.sv
// delayer_arb_rr_pkg: shared widths, default credit limit and log2 helper for the arbiter slice
`define ARB_ID_WD(n) func_log2(n)

package delayer_arb_rr_pkg;

    localparam int CRD_MAX_DEF = 2;

    // Bits needed to encode 0..n-1, never less than one
    function automatic int func_log2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/delayer_reg_based.sv
// delayer_reg_based: fixed-latency shift-register delay line, SIZE cycles from input to output
module delayer_reg_based
    import delayer_arb_rr_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int DATA_WD = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               val_i,
    input  logic [DATA_WD-1:0] dat_i,
    output logic               val_o,
    output logic [DATA_WD-1:0] dat_o
);

    logic [SIZE-1:0]    val_q;
    logic [DATA_WD-1:0] dat_q [SIZE];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            val_q <= '0;
            dat_q <= '{default: '0};
        end else begin
            val_q <= {val_q[SIZE-2:0], val_i};
            dat_q[0] <= dat_i;
            for (int i = 1; i < SIZE; i++) dat_q[i] <= dat_q[i-1];
        end
    end

    assign val_o = val_q[SIZE-1];
    assign dat_o = dat_q[SIZE-1];

endmodule

// File: rtl/delayer_arb_rr.sv
// delayer_arb_rr: round-robin, credit-limited arbiter sharing one fixed-latency delay line
module delayer_arb_rr
    import delayer_arb_rr_pkg::*;
#(
    parameter  int REQ_NUM = 4,
    parameter  int DATA_WD = 32,
    parameter  int SIZE    = 4,
    parameter  int CRD_MAX = CRD_MAX_DEF,
    localparam int ID_WD   = `ARB_ID_WD(REQ_NUM),
    localparam int CRD_WD  = func_log2(CRD_MAX + 1),
    localparam int CNT_WD  = func_log2(SIZE + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic [REQ_NUM-1:0]         req_val_i,
    input  logic [REQ_NUM*DATA_WD-1:0] req_dat_i,
    output logic [REQ_NUM-1:0]         req_rdy_o,
    input  logic [REQ_NUM-1:0]         crd_rtn_i,
    output logic [REQ_NUM-1:0]         out_val_o,
    output logic [ID_WD-1:0]           out_id_o,
    output logic [DATA_WD-1:0]         out_dat_o,
    output logic                       busy_o,
    output logic                       err_o
);

`ifdef SIM_KNOB_DBG
    initial begin
        if (SIZE < 2 || REQ_NUM < 2 || CRD_MAX < 1) begin
            $display("delayer_arb_rr: illegal parameters SIZE=%0d REQ_NUM=%0d CRD_MAX=%0d",
                     SIZE, REQ_NUM, CRD_MAX);
            $finish;
        end
    end
`endif

    logic [ID_WD-1:0]   ptr_q, ptr_d, gnt_id, dl_id;
    logic [CRD_WD-1:0]  crd_q [REQ_NUM];
    logic [CRD_WD-1:0]  crd_d [REQ_NUM];
    logic [CNT_WD-1:0]  cnt_q, cnt_d;
    logic               err_q, err_d, gnt_any, dl_val;
    logic [REQ_NUM-1:0] elig, gnt, ovf;
    logic [DATA_WD-1:0] dl_dat;

    always_comb begin
        int idx;
        idx = 0;
        gnt_any = 1'b0;
        gnt_id = '0;
        for (int k = 0; k < REQ_NUM; k++) elig[k] = !rst && en_i && req_val_i[k] && crd_q[k] != '0;
        // Walk downward so the eligible requester closest above ptr_q wins last
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % REQ_NUM;
            if (elig[idx]) begin
                gnt_any = 1'b1;
                gnt_id = ID_WD'(idx);
            end
        end
        gnt = gnt_any ? REQ_NUM'(1) << gnt_id : '0;
        ptr_d = !gnt_any ? ptr_q : gnt_id == ID_WD'(REQ_NUM - 1) ? '0 : gnt_id + ID_WD'(1);
        for (int k = 0; k < REQ_NUM; k++) begin
            ovf[k] = crd_rtn_i[k] && !gnt[k] && crd_q[k] == CRD_WD'(CRD_MAX);
            crd_d[k] = crd_q[k] - CRD_WD'(gnt[k]) + CRD_WD'(crd_rtn_i[k] && !ovf[k]);
        end
        err_d = err_q | (|ovf);
        cnt_d = cnt_q + CNT_WD'(gnt_any) - CNT_WD'(dl_val);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            crd_q <= '{default: CRD_WD'(CRD_MAX)};
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            crd_q <= crd_d;
        end
    end

    delayer_reg_based #(
        .SIZE    (SIZE),
        .DATA_WD (ID_WD + DATA_WD)
    ) u_dly (
        .clk   (clk),
        .rstn  (~rst),
        .val_i (gnt_any),
        .dat_i ({gnt_id, req_dat_i[gnt_id*DATA_WD +: DATA_WD]}),
        .val_o (dl_val),
        .dat_o ({dl_id, dl_dat})
    );

    // Gating by rst keeps outputs quiet in the very first reset cycle too
    assign req_rdy_o = gnt;
    assign out_val_o = (dl_val && !rst) ? REQ_NUM'(1) << dl_id : '0;
    assign out_id_o  = rst ? '0 : dl_id;
    assign out_dat_o = dl_dat;
    assign busy_o    = !rst && cnt_q != '0;
    assign err_o     = err_q && !rst;

endmodule
